win_checker: RTL and testbench

//  Downstream of the board-state register (2 bits per intersection). After each accepted placement
//  the game controller pulses start with the placed position. The block snapshots the board, walks
//  the four line directions through that stone one cell per clock, and reports whether its colour
//  has WIN_LEN or more in a row. Its result feeds the game-over logic and the LCD banner.

---
 rtl/win_checker.sv | 164 ++++++++++++++++
 tb/tb_win_checker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/win_checker.sv
// win_checker
//   Five-in-a-row detector for the board-state register. On an accepted start
//   the block snapshots the board and latches the placed position. It then walks
//   the four line directions through that stone, one cell per clock, and reports
//   whether the stone's colour forms a run of WIN_LEN or more.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   start        one-cycle request; pos and board_state are valid in that cycle
//   pos          index of the placed stone (row*(MAP_SIZE-1)+col)
//   board_state  2 bits per cell, cell k at [2k+:2]; 00 empty, 10 black, 11 white
//   busy         high while a request is in progress (ORIGIN through DONE)
//   done         one-cycle pulse; the result is valid in this cycle
//   win          a run of >= WIN_LEN was found; held until the next start or rst
//   winner       colour of the winning stone; 00 when win=0
//   win_dir      0 horiz, 1 vert, 2 diag (+1,+1), 3 anti-diag (+1,-1); 0 when win=0
module win_checker #(
  parameter int MAP_SIZE = 11,
  parameter int WIN_LEN  = 5
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [7:0]                             pos,
  input  logic [2*(MAP_SIZE-1)*(MAP_SIZE-1)-1:0] board_state,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   win,
  output logic [1:0]                             winner,
  output logic [1:0]                             win_dir
);

  localparam int SIDE  = MAP_SIZE - 1;
  localparam int CELLS = SIDE * SIDE;
  localparam int BW    = 2 * CELLS;

  localparam logic signed [7:0] SIDE_S  = 8'(SIDE);
  localparam logic [7:0]        SIDE_U  = 8'(SIDE);
  localparam logic [7:0]        CELLS_U = 8'(CELLS);
  localparam logic [3:0]        K_LAST  = 4'(WIN_LEN - 1);
  localparam logic [3:0]        WIN_CNT = 4'(WIN_LEN);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ORIGIN = 3'd1;
  localparam logic [2:0] ST_POS    = 3'd2;
  localparam logic [2:0] ST_NEG    = 3'd3;
  localparam logic [2:0] ST_EVAL   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic [2:0]    state;
  logic [BW-1:0] snap;
  logic [7:0]    pos_q;
  logic [1:0]    colour;
  logic [1:0]    dir;
  logic [3:0]    count;
  logic [3:0]    k;

  logic [7:0]        row_u, col_u;
  logic signed [7:0] dr_s, dc_s, kk_s, pr_s, pc_s;
  logic              in_bounds;
  logic [7:0]        probe_idx;
  logic [1:0]        probe;
  logic              match;
  logic              pos_ok;
  logic [1:0]        origin_c;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // Probe address: origin +/- k*(dr,dc). Row and column are bounds-checked
  // independently so a horizontal run never wraps onto the next row.
  always_comb begin
    row_u = pos_q / SIDE_U;
    col_u = pos_q % SIDE_U;
    dr_s  = (dir == 2'd0) ? 8'sd0 : 8'sd1;
    case (dir)
      2'd0:    dc_s = 8'sd1;
      2'd1:    dc_s = 8'sd0;
      2'd2:    dc_s = 8'sd1;
      default: dc_s = -8'sd1;
    endcase
    kk_s = $signed({4'b0000, k});
    if (state == ST_NEG) kk_s = -kk_s;
    pr_s = $signed(row_u) + kk_s * dr_s;
    pc_s = $signed(col_u) + kk_s * dc_s;
    in_bounds = (pr_s >= 8'sd0) && (pr_s < SIDE_S) &&
                (pc_s >= 8'sd0) && (pc_s < SIDE_S);
    probe_idx = 8'd0;
    if (in_bounds) probe_idx = $unsigned(pr_s) * SIDE_U + $unsigned(pc_s);
    probe = snap[{probe_idx, 1'b0} +: 2];
    match = in_bounds && (probe == colour);
    // An out-of-range pos must not address past the snapshot.
    pos_ok   = (pos_q < CELLS_U);
    origin_c = snap[{(pos_ok ? pos_q : 8'd0), 1'b0} +: 2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      snap    <= '0;
      pos_q   <= '0;
      colour  <= '0;
      dir     <= '0;
      count   <= '0;
      k       <= '0;
      win     <= 1'b0;
      winner  <= 2'b00;
      win_dir <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pos_q   <= pos;
            snap    <= board_state;
            win     <= 1'b0;
            winner  <= 2'b00;
            win_dir <= 2'd0;
            state   <= ST_ORIGIN;
          end
        end
        ST_ORIGIN: begin
          colour <= origin_c;
          if (!pos_ok || !origin_c[1]) begin
            state <= ST_DONE;
          end else begin
            dir   <= 2'd0;
            count <= 4'd1;
            k     <= 4'd1;
            state <= ST_POS;
          end
        end
        ST_POS, ST_NEG: begin
          // The walk in one direction stops at the first miss or after WIN_LEN-1 cells.
          if (match) count <= count + 4'd1;
          if (match && (k != K_LAST)) begin
            k <= k + 4'd1;
          end else begin
            k     <= 4'd1;
            state <= (state == ST_POS) ? ST_NEG : ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (count >= WIN_CNT) begin
            win     <= 1'b1;
            winner  <= colour;
            win_dir <= dir;
            state   <= ST_DONE;
          end else if (dir == 2'd3) begin
            state <= ST_DONE;
          end else begin
            dir   <= dir + 2'd1;
            count <= 4'd1;
            k     <= 4'd1;
            state <= ST_POS;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_win_checker.sv
module tb_win_checker;

  localparam int MAP_SIZE = 11;
  localparam int WIN_LEN  = 5;
  localparam int BW       = 2 * (MAP_SIZE - 1) * (MAP_SIZE - 1);
  localparam int MAX_LAT  = 2 + 4 * (2 * (WIN_LEN - 1) + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    pos;
  logic [BW-1:0] board_state;
  logic          busy, done, win;
  logic [1:0]    winner, win_dir;

  win_checker #(.MAP_SIZE(MAP_SIZE), .WIN_LEN(WIN_LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .pos(pos), .board_state(board_state),
    .busy(busy), .done(done), .win(win), .winner(winner), .win_dir(win_dir)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string         name;
    logic [BW-1:0] board;
    logic [7:0]    pos;
    logic          w;
    logic [1:0]    c;
    logic [1:0]    d;
    int            lat;   // exact latency, 0 = only the worst-case bound applies
  } vec_t;

  typedef struct {
    string      name;
    logic       w;
    logic [1:0] c;
    logic [1:0] d;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   ndone  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  function automatic logic [BW-1:0] line(input logic [1:0] c, input int p0,
                                         input int step, input int n);
    logic [BW-1:0] b = '0;
    for (int i = 0; i < n; i++) b[2*(p0+i*step) +: 2] = c;
    return b;
  endfunction

  // Scoreboard: every done pulse pops the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && done === 1'b1) begin
        ndone++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, required no pending request");
        end else begin
          e = sb.pop_front();
          chk({e.name, "_win"},    32'(win),     32'(e.w));
          chk({e.name, "_winner"}, 32'(winner),  32'(e.c));
          chk({e.name, "_dir"},    32'(win_dir), 32'(e.d));
        end
      end
    end
  end

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.name = v.name; e.w = v.w; e.c = v.c; e.d = v.d;
    sb.push_back(e);
  endtask

  // Returns latency in cycles from the start cycle to the done cycle, -1 on timeout.
  task automatic wait_done(input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < MAX_LAT + 8; i++) begin
      if (done === 1'b1) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_case(input vec_t v);
    int t0, lat;
    @(negedge clk);
    board_state = v.board; pos = v.pos; start = 1'b1;
    t0 = cyc;
    push_exp(v);
    @(negedge clk);
    start = 1'b0;
    board_state = '1;   // must not affect the running scan
    pos = 8'h00;
    chk({v.name, "_busy"}, 32'(busy), 32'd1);
    wait_done(t0, lat);
    chk({v.name, "_done_seen"}, 32'(lat >= 0), 32'd1);
    if (lat < 0) sb.delete();
    else if (v.lat > 0) chk({v.name, "_latency"}, lat, v.lat);
    else chk({v.name, "_lat_bound"}, 32'(lat <= MAX_LAT), 32'd1);
    @(negedge clk);
    chk({v.name, "_idle_busy"}, 32'(busy), 32'd0);
    chk({v.name, "_held_win"},  32'(win),  32'(v.w));
    board_state = '0;
  endtask

  vec_t tbl[12];

  initial begin
    int t0, lat, n0;

    tbl[0]  = '{"horiz_black",  line(2'b10, 42, 1, 5), 8'd44, 1'b1, 2'b10, 2'd0, 9};
    tbl[1]  = '{"four_only",    line(2'b10, 41, 1, 4), 8'd43, 1'b0, 2'b00, 2'd0, 0};
    tbl[2]  = '{"no_wrap",      line(2'b10, 7, 1, 5),  8'd9,  1'b0, 2'b00, 2'd0, 0};
    tbl[3]  = '{"anti_white",   line(2'b11, 4, 9, 5),  8'd22, 1'b1, 2'b11, 2'd3, 0};
    tbl[4]  = '{"over_edge",    line(2'b11, 20, 1, 6), 8'd20, 1'b1, 2'b11, 2'd0, 0};
    tbl[5]  = '{"over_mid",     line(2'b11, 20, 1, 6), 8'd22, 1'b1, 2'b11, 2'd0, 0};
    tbl[6]  = '{"empty_origin", '0,                    8'd0,  1'b0, 2'b00, 2'd0, 2};
    tbl[7]  = '{"vert_black",   line(2'b10, 53, 10, 5), 8'd93, 1'b1, 2'b10, 2'd1, 0};
    tbl[8]  = '{"diag_white",   line(2'b11, 0, 11, 5), 8'd0,  1'b1, 2'b11, 2'd2, 0};
    tbl[9]  = '{"pos_range",    line(2'b10, 42, 1, 5), 8'd100, 1'b0, 2'b00, 2'd0, 2};
    tbl[10] = '{"mixed_colour", line(2'b10, 42, 1, 5), 8'd43, 1'b0, 2'b00, 2'd0, 0};
    tbl[10].board[2*44 +: 2] = 2'b11;
    tbl[11] = '{"horiz_first",  line(2'b10, 42, 1, 5) | line(2'b10, 24, 10, 2) |
                                line(2'b10, 54, 10, 2), 8'd44, 1'b1, 2'b10, 2'd0, 9};

    rst = 1'b1; start = 1'b0; pos = '0; board_state = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy",    32'(busy),    32'd0);
    chk("reset_done",    32'(done),    32'd0);
    chk("reset_win",     32'(win),     32'd0);
    chk("reset_winner",  32'(winner),  32'd0);
    chk("reset_win_dir", 32'(win_dir), 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) run_case(tbl[i]);

    // Second start while busy: ignored, one done carrying the first request's result.
    n0 = ndone;
    @(negedge clk);
    board_state = tbl[0].board; pos = tbl[0].pos; start = 1'b1;
    t0 = cyc;
    push_exp(tbl[0]);
    @(negedge clk);
    start = 1'b0; board_state = '0;
    @(negedge clk);
    start = 1'b1; pos = 8'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done(t0, lat);
    chk("busy_start_latency", lat, 9);
    if (lat < 0) sb.delete();
    repeat (MAX_LAT + 5) @(negedge clk);
    chk("busy_start_one_done", ndone - n0, 1);

    // rst while idle clears a held win.
    chk("held_win_before_rst", 32'(win), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("idle_rst_win",    32'(win),    32'd0);
    chk("idle_rst_winner", 32'(winner), 32'd0);

    // rst mid-scan aborts without a done pulse.
    @(negedge clk);
    board_state = tbl[11].board; pos = tbl[11].pos; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_scan_busy", 32'(busy), 32'd1);
    n0 = ndone;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy",    32'(busy),    32'd0);
    chk("abort_done",    32'(done),    32'd0);
    chk("abort_win",     32'(win),     32'd0);
    chk("abort_winner",  32'(winner),  32'd0);
    chk("abort_win_dir", 32'(win_dir), 32'd0);
    repeat (MAX_LAT + 5) @(negedge clk);
    chk("abort_no_done", ndone - n0, 0);

    run_case(tbl[3]);
    run_case(tbl[1]);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before time limit");
    $fatal(1);
  end

endmodule
